// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// Holds FSM state encoding, exception code constants, default vectors
// and the redirect-target decode used on exception entry.
package pipe_ctrl_pkg;

  typedef logic [0:0] pipe_state_t;

  localparam pipe_state_t ST_RUN   = 1'b0;
  localparam pipe_state_t ST_FLUSH = 1'b1;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] EXC_INT     = 32'h0000_0001;
  localparam logic [XLEN-1:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [XLEN-1:0] EXC_RI      = 32'h0000_000A;
  localparam logic [XLEN-1:0] EXC_OV      = 32'h0000_000C;
  localparam logic [XLEN-1:0] EXC_TRAP    = 32'h0000_000D;
  localparam logic [XLEN-1:0] EXC_ERET    = 32'h0000_000E;

  localparam logic [XLEN-1:0] DEF_VEC_INT = 32'h0000_0020;
  localparam logic [XLEN-1:0] DEF_VEC_GEN = 32'h0000_0040;

  // Map an exception code to its redirect target; unknown codes redirect to 0.
  function automatic logic [XLEN-1:0] redirect_pc(
    input logic [XLEN-1:0] code,
    input logic [XLEN-1:0] epc,
    input logic [XLEN-1:0] vec_int,
    input logic [XLEN-1:0] vec_gen
  );
    logic [XLEN-1:0] pc;
    pc = '0;
    case (code)
      EXC_INT:                             pc = vec_int;
      EXC_SYSCALL, EXC_RI, EXC_OV, EXC_TRAP: pc = vec_gen;
      EXC_ERET:                            pc = epc;
      default:                             pc = '0;
    endcase
    return pc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_gen_stall_mask_enc.sv
// Highest-set-bit to thermometer mask: every stage at or below the
// most-downstream requester holds.
module stall_mask_enc #(
  parameter int unsigned NSTAGE = 6
) (
  input  logic [NSTAGE-1:0] req_i,
  output logic [NSTAGE-1:0] mask_c_o
);

  // Running OR from the top bit down yields the thermometer mask.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    mask_c_o = '0;
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      acc         = acc | req_i[i];
      mask_c_o[i] = acc;
    end
  end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller.
// Produces a combinational stall mask, a registered one-cycle flush pulse
// with its redirect PC, and (with PIPE_CTRL_WDOG_EN defined) a sticky
// stall-watchdog timeout flag.
module pipe_ctrl_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE  = 6,
  parameter int unsigned WDOG_W  = 8,
  parameter logic [31:0] VEC_INT = DEF_VEC_INT,
  parameter logic [31:0] VEC_GEN = DEF_VEC_GEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       cp0_epc_i,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              wdog_timeout
);

  pipe_state_t       state_q, state_d;
  logic              flush_q, flush_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic [NSTAGE-1:0] mask_c;
  logic [NSTAGE-1:0] stall_c;
  logic              exc_c;

  stall_mask_enc #(.NSTAGE(NSTAGE)) u_mask (
    .req_i    (stall_req),
    .mask_c_o (mask_c)
  );

  assign exc_c = (excepttype_i != 32'h0);

  // Next-state, flush pulse and stall mask; stall only passes in quiet RUN.
  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    new_pc_d = '0;
    stall_c  = '0;
    case (state_q)
      ST_RUN: begin
        if (exc_c) begin
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          new_pc_d = redirect_pc(excepttype_i, cp0_epc_i, VEC_INT, VEC_GEN);
        end else begin
          stall_c = mask_c;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (!reset_n) stall_c = '0;
  end

  // State and flush/redirect registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign stall  = stall_c;
  assign flush  = flush_q;
  assign new_pc = new_pc_q;

`ifdef PIPE_CTRL_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

  logic [WDOG_W-1:0] wcnt_q, wcnt_d;
  logic              wto_q, wto_d;

  // Count consecutive stalled RUN cycles, saturating; timeout is sticky.
  always_comb begin
    wcnt_d = '0;
    wto_d  = wto_q;
    if ((state_q == ST_RUN) && (stall_c != '0)) begin
      wcnt_d = (wcnt_q == WDOG_MAX) ? wcnt_q : wcnt_q + WDOG_W'(1);
    end
    if (wcnt_d == WDOG_MAX) wto_d = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wcnt_q <= '0;
      wto_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wto_q  <= wto_d;
    end
  end

  assign wdog_timeout = wto_q;
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl_gen.md
PIPE_CTRL_GEN -- requirements
Module: pipe_ctrl_gen

Interface
REQ-001 Parameter NSTAGE, default 6: number of pipeline stages; stall vector width; minimum 2.
REQ-002 Parameter WDOG_W, default 8: stall watchdog counter width.
REQ-003 Parameter VEC_INT, default 32'h00000020: interrupt handler address.
REQ-004 Parameter VEC_GEN, default 32'h00000040: general exception handler address.
REQ-005 clk  input  1: rising-edge clock.
REQ-006 reset_n  input  1: reset, synchronous, active-low.
REQ-007 stall_req  input  NSTAGE: bit i set = stage i requests a stall.
REQ-008 excepttype_i  input  32: exception code from commit stage; 0 = none.
REQ-009 cp0_epc_i  input  32: exception return address.
REQ-010 stall  output  NSTAGE: bit i set = stage i holds.
REQ-011 flush  output  1: registered one-cycle pipeline flush pulse.
REQ-012 new_pc  output  32: redirect target; valid only while flush=1, else 0.
REQ-013 wdog_timeout  output  1: sticky stall-timeout flag.

Function
REQ-014 State machine SHALL have two states: RUN and FLUSH.
REQ-015 In RUN, stall SHALL be combinational: k = highest set bit of stall_req; stall[k:0] all 1, stall[NSTAGE-1:k+1] all 0; stall_req=0 gives stall=0.
REQ-016 In RUN with excepttype_i != 0 at edge N, the FSM SHALL enter FLUSH; flush=1 and new_pc valid during cycle N+1 only (latency 1).
REQ-017 new_pc SHALL be captured at edge N: code 0x1 -> VEC_INT; codes 0x8, 0xA, 0xC, 0xD -> VEC_GEN; code 0xE -> cp0_epc_i sampled at edge N; any other nonzero code -> 0.
REQ-018 In the cycle excepttype_i != 0 (still RUN), stall SHALL be forced to 0 regardless of stall_req.
REQ-019 In FLUSH, stall SHALL be 0, and stall_req and excepttype_i SHALL be ignored.
REQ-020 FLUSH SHALL last exactly one cycle, then return to RUN; back-to-back exceptions therefore give flush pulses at most every other cycle.
REQ-021 In RUN with excepttype_i=0, flush=0 and new_pc=0.

Reset
REQ-022 While reset_n=0 at a rising edge: state=RUN, flush=0, new_pc=0, watchdog counter=0, wdog_timeout=0.
REQ-023 While reset_n=0, stall SHALL be forced to 0 combinationally.
REQ-024 Reset during FLUSH SHALL abort the flush; after release, flush=0 until a new exception occurs.

Configuration
REQ-025 Macro PIPE_CTRL_WDOG_EN: when defined, a WDOG_W-bit counter increments on each RUN cycle with stall != 0 and clears on any cycle with stall=0 or in FLUSH.
REQ-026 When the counter reaches 2^WDOG_W-1, it SHALL saturate and set wdog_timeout; wdog_timeout is cleared only by reset.
REQ-027 When PIPE_CTRL_WDOG_EN is undefined, the counter SHALL be absent and wdog_timeout tied to 0.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold the FSM state typedef, the excepttype code constants (0x1, 0x8, 0xA, 0xC, 0xD, 0xE) and the default vector constants.
REQ-029 Sub-module stall_mask_enc SHALL perform the highest-set-bit to thermometer-mask conversion of REQ-015.

Verification
REQ-030 NSTAGE=6, stall_req=6'b000100 -> stall=6'b000111; stall_req=6'b001100 -> stall=6'b001111, same cycle.
REQ-031 excepttype_i=0x8 with stall_req=6'b001000 at edge N -> stall=0 in cycle N; flush=1, new_pc=0x40 in cycle N+1; flush=0 in cycle N+2.
REQ-032 excepttype_i=0xE, cp0_epc_i=0x1234 at edge N, cp0_epc_i changed to 0 in cycle N+1 -> new_pc=0x1234 in cycle N+1.
REQ-033 excepttype_i=0x1 held for 3 cycles -> flush pattern 1,0,1 in cycles N+1..N+3 with new_pc=0x20; excepttype_i=0x5 -> flush=1, new_pc=0.
REQ-034 reset_n=0 in cycle N+1 during FLUSH -> flush=0, stall=0 from cycle N+2, and no flush pulse after release.
REQ-035 PIPE_CTRL_WDOG_EN defined, WDOG_W=4, stall_req=1 held -> wdog_timeout=1 after 15 stalled cycles and stays 1 after the stall is removed; undefined -> wdog_timeout stays 0.
